// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, counter widths, helpers.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pll_rst_pkg;

  localparam logic [1:0] HOLD     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] RELEASE  = 2'd2;
  localparam logic [1:0] RUN      = 2'd3;

  localparam int LOSS_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_HOLD     = HOLD,
    ST_DEBOUNCE = DEBOUNCE,
    ST_RELEASE  = RELEASE,
    ST_RUN      = RUN
  } pll_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser with asynchronous active-low clear.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; free-running.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Turns the raw PLL lock flag into a debounced, held-off system reset and counts lock losses.
// Latency: lock -> release in SYNC_STAGES+LOCK_STABLE+RST_HOLD+1 edges; lock loss -> reset in SYNC_STAGES+1.
// Backpressure: none; sw_rst_req is honoured only in RUN and otherwise dropped.
module pll_reset_seq
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE = 1024,
  parameter int RST_HOLD    = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  pll_lock,
  input  logic                  sw_rst_req,
  output logic                  sys_resetn,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [1:0]            state
);

  localparam int CNT_W = $clog2(max_int(LOCK_STABLE, RST_HOLD) + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX = '1;

  logic                  lock_s;
  pll_state_e            cur_st;
  pll_state_e            nxt_st;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [LOSS_CNT_W-1:0] loss_nxt;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pll_lock),
    .q      (lock_s)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_st        <= ST_HOLD;
      cnt           <= '0;
      lock_loss_cnt <= '0;
      sys_resetn    <= 1'b0;
      ready         <= 1'b0;
    end else begin
      cur_st        <= nxt_st;
      cnt           <= cnt_nxt;
      lock_loss_cnt <= loss_nxt;
      // Outputs follow the next state so they switch on the same edge as state.
      sys_resetn    <= (nxt_st == ST_RUN);
      ready         <= (nxt_st == ST_RUN);
    end
  end

  always_comb begin
    nxt_st   = cur_st;
    cnt_nxt  = cnt;
    loss_nxt = lock_loss_cnt;
    case (cur_st)
      ST_HOLD: begin
        cnt_nxt = '0;
        if (lock_s) begin
          nxt_st = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (!lock_s) begin
          nxt_st  = ST_HOLD;
          cnt_nxt = '0;
        end else if (cnt == STABLE_LAST) begin
          nxt_st  = ST_RELEASE;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!lock_s) begin
          nxt_st  = ST_HOLD;
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          nxt_st  = ST_RUN;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_nxt = '0;
        // Lock loss wins over a coincident soft reset so the event is always counted.
        if (!lock_s) begin
          nxt_st = ST_HOLD;
          if (lock_loss_cnt != LOSS_MAX) begin
            loss_nxt = lock_loss_cnt + 1'b1;
          end
        end else if (sw_rst_req) begin
          nxt_st = ST_RELEASE;
        end
      end
      default: begin
        nxt_st  = ST_HOLD;
        cnt_nxt = '0;
      end
    endcase
  end

  assign state = cur_st;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scenario tests for pll_reset_seq against a run-length reference model of lock history.
module tb_pll_reset_seq;

  localparam int SYNC = 2;
  localparam int LS   = 4;
  localparam int RH   = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pll_lock = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       sys_resetn;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic [1:0] state;

  int errs = 0;
  int checks = 0;

  // Model: m_r = consecutive edges on which the FSM has seen lock_s high.
  int              m_r = 0;
  int              m_loss = 0;
  logic [SYNC-1:0] m_hist = '0;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .SYNC_STAGES (SYNC),
    .LOCK_STABLE (LS),
    .RST_HOLD    (RH)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pll_lock      (pll_lock),
    .sw_rst_req    (sw_rst_req),
    .sys_resetn    (sys_resetn),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt),
    .state         (state)
  );

  function automatic int st_of(input int r);
    if (r == 0) return 0;
    if (r <= LS) return 1;
    if (r <= LS + RH) return 2;
    return 3;
  endfunction

  task automatic model_clear();
    m_r = 0;
    m_loss = 0;
    m_hist = '0;
  endtask

  task automatic step(input logic lk, input logic sw);
    logic ls;
    int   prev;
    pll_lock = lk;
    sw_rst_req = sw;
    @(posedge clk);
    ls = m_hist[SYNC-1];
    prev = st_of(m_r);
    if (!ls) begin
      if (prev == 3 && m_loss < 255) m_loss++;
      m_r = 0;
    end else if (prev == 3 && sw) begin
      m_r = LS + 1;
    end else if (m_r <= LS + RH) begin
      m_r++;
    end
    m_hist = {m_hist[SYNC-2:0], lk};
    #1;
    sw_rst_req = 1'b0;
  endtask

  task automatic hard_reset(input logic lk);
    resetn = 1'b0;
    pll_lock = lk;
    sw_rst_req = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic goto_run();
    for (int i = 0; i < 40 && st_of(m_r) != 3; i++) step(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    int edge_n;
    resetn = 1'b0;
    pll_lock = 1'b1;
    sw_rst_req = 1'b0;
    model_clear();
    repeat (5) begin
      @(posedge clk);
      #1;
      checks++;
      if (sys_resetn !== 1'b0 || state !== 2'd0 || ready !== 1'b0 || lock_loss_cnt !== 8'd0) begin
        errs++;
        $display("FAIL reset_hold: sys_resetn=%b state=%0d ready=%b loss=%0d, required 0/0/0/0", sys_resetn, state, ready, lock_loss_cnt);
      end
    end
    resetn = 1'b1;
    edge_n = 0;
    for (int i = 1; i <= 20 && edge_n == 0; i++) begin
      step(1'b1, 1'b0);
      if (sys_resetn === 1'b1) edge_n = i;
    end
    checks++;
    if (edge_n !== 10) begin
      errs++;
      $display("FAIL powerup_release_edge: got edge %0d, required 10", edge_n);
    end
    checks++;
    if (state !== 2'd3 || ready !== 1'b1 || lock_loss_cnt !== 8'd0) begin
      errs++;
      $display("FAIL powerup_run: state=%0d ready=%b loss=%0d, required 3/1/0", state, ready, lock_loss_cnt);
    end
  endtask

  task automatic test_glitch();
    bit visited1;
    bit rose;
    int len;
    hard_reset(1'b0);
    repeat (4) step(1'b0, 1'b0);
    visited1 = 0;
    rose = 0;
    for (int i = 0; i < 9; i++) begin
      step((i < 3) ? 1'b1 : 1'b0, 1'b0);
      if (state === 2'd1) visited1 = 1;
      if (sys_resetn !== 1'b0) rose = 1;
    end
    checks++;
    if (!visited1 || rose || state !== 2'd0 || lock_loss_cnt !== 8'd0) begin
      errs++;
      $display("FAIL glitch_basic: visited1=%0d rose=%0d state=%0d loss=%0d, required 1/0/0/0", visited1, rose, state, lock_loss_cnt);
    end
    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(1, LS);
      for (int i = 0; i < len + SYNC + 3; i++) begin
        step((i < len) ? 1'b1 : 1'b0, 1'b0);
        checks++;
        if (sys_resetn !== 1'b0 || state !== 2'(st_of(m_r))) begin
          errs++;
          $display("FAIL glitch_rand len=%0d: sys_resetn=%b state=%0d, required 0/%0d", len, sys_resetn, state, st_of(m_r));
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    int loss0;
    int edge_n;
    goto_run();
    loss0 = m_loss;
    edge_n = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0);
      if (edge_n == 0 && sys_resetn === 1'b0) edge_n = i;
    end
    checks++;
    if (edge_n !== 3) begin
      errs++;
      $display("FAIL loss_reset_edge: got edge %0d, required 3", edge_n);
    end
    checks++;
    if (state !== 2'd0 || lock_loss_cnt !== 8'(loss0 + 1)) begin
      errs++;
      $display("FAIL loss_count: state=%0d loss=%0d, required 0/%0d", state, lock_loss_cnt, loss0 + 1);
    end
    edge_n = 0;
    for (int i = 1; i <= 20 && edge_n == 0; i++) begin
      step(1'b1, 1'b0);
      if (sys_resetn === 1'b1) edge_n = i;
    end
    checks++;
    if (edge_n !== 10) begin
      errs++;
      $display("FAIL relock_edge: got edge %0d, required 10", edge_n);
    end
  endtask

  task automatic test_soft_reset();
    int loss0;
    goto_run();
    loss0 = m_loss;
    step(1'b1, 1'b1);
    checks++;
    if (sys_resetn !== 1'b0 || state !== 2'd2) begin
      errs++;
      $display("FAIL soft_assert: sys_resetn=%b state=%0d, required 0/2", sys_resetn, state);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (sys_resetn !== 1'b0 || state !== 2'd2) begin
        errs++;
        $display("FAIL soft_hold%0d: sys_resetn=%b state=%0d, required 0/2", i, sys_resetn, state);
      end
    end
    step(1'b1, 1'b0);
    checks++;
    if (sys_resetn !== 1'b1 || state !== 2'd3 || lock_loss_cnt !== 8'(loss0)) begin
      errs++;
      $display("FAIL soft_release: sys_resetn=%b state=%0d loss=%0d, required 1/3/%0d", sys_resetn, state, lock_loss_cnt, loss0);
    end
    repeat (SYNC + 1) step(1'b0, 1'b0);
    for (int i = 0; i < 20 && st_of(m_r) != 1; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (state !== 2'd1 || state !== 2'(st_of(m_r))) begin
      errs++;
      $display("FAIL soft_in_debounce: state=%0d, required 1", state);
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (state !== 2'(st_of(m_r)) || sys_resetn !== (st_of(m_r) == 3)) begin
        errs++;
        $display("FAIL soft_recover%0d: state=%0d sys_resetn=%b, required %0d", i, state, sys_resetn, st_of(m_r));
      end
    end
  endtask

  task automatic test_simultaneous();
    int loss0;
    goto_run();
    loss0 = m_loss;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    checks++;
    if (state !== 2'd0 || sys_resetn !== 1'b0 || lock_loss_cnt !== 8'(loss0 + 1)) begin
      errs++;
      $display("FAIL simultaneous: state=%0d sys_resetn=%b loss=%0d, required 0/0/%0d", state, sys_resetn, lock_loss_cnt, loss0 + 1);
    end
    for (int k = 0; k < 260; k++) begin
      goto_run();
      repeat (SYNC + 1) step(1'b0, 1'b0);
      checks++;
      if (lock_loss_cnt !== 8'(m_loss)) begin
        errs++;
        $display("FAIL saturate_step%0d: loss=%0d, required %0d", k, lock_loss_cnt, m_loss);
      end
    end
    checks++;
    if (lock_loss_cnt !== 8'd255 || state !== 2'd0) begin
      errs++;
      $display("FAIL saturate_final: loss=%0d state=%0d, required 255/0", lock_loss_cnt, state);
    end
  endtask

  task automatic test_async_release();
    for (int i = 0; i < 30 && st_of(m_r) != 2; i++) step(1'b1, 1'b0);
    checks++;
    if (state !== 2'd2) begin
      errs++;
      $display("FAIL async_reach_release: state=%0d, required 2", state);
    end
    #3;
    resetn = 1'b0;
    #1;
    model_clear();
    checks++;
    if (sys_resetn !== 1'b0 || ready !== 1'b0 || state !== 2'd0 || lock_loss_cnt !== 8'd0) begin
      errs++;
      $display("FAIL async_immediate: sys_resetn=%b ready=%b state=%0d loss=%0d, required 0/0/0/0", sys_resetn, ready, state, lock_loss_cnt);
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    checks++;
    if (sys_resetn !== 1'b0 || state !== 2'd0) begin
      errs++;
      $display("FAIL async_after_edge: sys_resetn=%b state=%0d, required 0/0", sys_resetn, state);
    end
  endtask

  task automatic test_random();
    logic lk;
    logic sw;
    hard_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      lk = ($urandom_range(0, 19) != 0);
      sw = ($urandom_range(0, 9) == 0);
      step(lk, sw);
      checks++;
      if (state !== 2'(st_of(m_r)) || sys_resetn !== (st_of(m_r) == 3) || ready !== (st_of(m_r) == 3) || lock_loss_cnt !== 8'(m_loss)) begin
        errs++;
        $display("FAIL random cyc%0d: state=%0d sys_resetn=%b ready=%b loss=%0d, required %0d/%0d/%0d/%0d", i, state, sys_resetn, ready, lock_loss_cnt, st_of(m_r), st_of(m_r) == 3, st_of(m_r) == 3, m_loss);
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_glitch();
    test_lock_loss();
    test_soft_reset();
    test_simultaneous();
    test_async_release();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
